// File: rtl/split_3o.sv
// Splits a per-position stream of N1+N2+N3 concatenated channel words into three
// group outputs with one cycle of latency; the inverse of a three-input concat merge.
module split_3o #(
    parameter int unsigned IMG_WIDTH  = 17,
    parameter int unsigned N1         = 1,
    parameter int unsigned N2         = 1,
    parameter int unsigned N3         = 1,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out_1,
    output logic [DATA_WIDTH-1:0] pxl_out_2,
    output logic [DATA_WIDTH-1:0] pxl_out_3,
    output logic                  valid_out_1,
    output logic                  valid_out_2,
    output logic                  valid_out_3,
    output logic                  frame_done
);

    localparam int unsigned TOTAL  = IMG_WIDTH * IMG_WIDTH;
    localparam int unsigned POS_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int unsigned N_12   = (N1 > N2) ? N1 : N2;
    localparam int unsigned N_MAX  = (N_12 > N3) ? N_12 : N3;
    localparam int unsigned CH_W   = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] G1 = 2'd0;
    localparam logic [STATE_W-1:0] G2 = 2'd1;
    localparam logic [STATE_W-1:0] G3 = 2'd2;

    logic [STATE_W-1:0]    state_q,     state_d;
    logic [CH_W-1:0]       ch_cnt_q,    ch_cnt_d;
    logic [POS_W-1:0]      pos_cnt_q,   pos_cnt_d;
    logic [DATA_WIDTH-1:0] pxl_out_1_q, pxl_out_1_d;
    logic [DATA_WIDTH-1:0] pxl_out_2_q, pxl_out_2_d;
    logic [DATA_WIDTH-1:0] pxl_out_3_q, pxl_out_3_d;
    logic                  valid_out_1_q, valid_out_1_d;
    logic                  valid_out_2_q, valid_out_2_d;
    logic                  valid_out_3_q, valid_out_3_d;
    logic                  frame_done_q,  frame_done_d;

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= G1;
            ch_cnt_q      <= '0;
            pos_cnt_q     <= '0;
            pxl_out_1_q   <= '0;
            pxl_out_2_q   <= '0;
            pxl_out_3_q   <= '0;
            valid_out_1_q <= 1'b0;
            valid_out_2_q <= 1'b0;
            valid_out_3_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_cnt_q      <= ch_cnt_d;
            pos_cnt_q     <= pos_cnt_d;
            pxl_out_1_q   <= pxl_out_1_d;
            pxl_out_2_q   <= pxl_out_2_d;
            pxl_out_3_q   <= pxl_out_3_d;
            valid_out_1_q <= valid_out_1_d;
            valid_out_2_q <= valid_out_2_d;
            valid_out_3_q <= valid_out_3_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Routing and group sequencing; an idle input freezes everything but the strobes.
    always_comb begin
        state_d       = state_q;
        ch_cnt_d      = ch_cnt_q;
        pos_cnt_d     = pos_cnt_q;
        pxl_out_1_d   = pxl_out_1_q;
        pxl_out_2_d   = pxl_out_2_q;
        pxl_out_3_d   = pxl_out_3_q;
        valid_out_1_d = 1'b0;
        valid_out_2_d = 1'b0;
        valid_out_3_d = 1'b0;
        frame_done_d  = 1'b0;

        if (valid_in) begin
            case (state_q)
                G1: begin
                    pxl_out_1_d   = pxl_in;
                    valid_out_1_d = 1'b1;
                    if (ch_cnt_q == CH_W'(N1 - 1)) begin
                        state_d  = G2;
                        ch_cnt_d = '0;
                    end else begin
                        ch_cnt_d = ch_cnt_q + CH_W'(1);
                    end
                end
                G2: begin
                    pxl_out_2_d   = pxl_in;
                    valid_out_2_d = 1'b1;
                    if (ch_cnt_q == CH_W'(N2 - 1)) begin
                        state_d  = G3;
                        ch_cnt_d = '0;
                    end else begin
                        ch_cnt_d = ch_cnt_q + CH_W'(1);
                    end
                end
                G3: begin
                    pxl_out_3_d   = pxl_in;
                    valid_out_3_d = 1'b1;
                    if (ch_cnt_q == CH_W'(N3 - 1)) begin
                        state_d  = G1;
                        ch_cnt_d = '0;
                        // Position closes here; the last position of the frame also closes the frame.
                        if (pos_cnt_q == POS_W'(TOTAL - 1)) begin
                            pos_cnt_d    = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            pos_cnt_d = pos_cnt_q + POS_W'(1);
                        end
                    end else begin
                        ch_cnt_d = ch_cnt_q + CH_W'(1);
                    end
                end
                default: begin
                    state_d  = G1;
                    ch_cnt_d = '0;
                end
            endcase
        end
    end

    assign pxl_out_1   = pxl_out_1_q;
    assign pxl_out_2   = pxl_out_2_q;
    assign pxl_out_3   = pxl_out_3_q;
    assign valid_out_1 = valid_out_1_q;
    assign valid_out_2 = valid_out_2_q;
    assign valid_out_3 = valid_out_3_q;
    assign frame_done  = frame_done_q;

endmodule
